// File: rtl/cmp_sched_if.sv
// cmp_sched_if: request/response and shared-comparator signals of the compare scheduler
interface cmp_sched_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_op_a;
    logic [N_REQ*WIDTH-1:0] req_op_b;
    logic [WIDTH-1:0]       cmp_a;
    logic [WIDTH-1:0]       cmp_b;
    logic [WIDTH-1:0]       cmp_r;
    logic [N_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]       rsp_r;
    logic                   busy;
    modport slave (
        input  req_valid, req_op_a, req_op_b, cmp_r,
        output req_ready, cmp_a, cmp_b, rsp_valid, rsp_r, busy
    );
    modport master (
        output req_valid, req_op_a, req_op_b, cmp_r,
        input  req_ready, cmp_a, cmp_b, rsp_valid, rsp_r, busy
    );
endinterface

// File: rtl/cmp_sched.sv
// cmp_sched: round-robin arbiter serialising requesters onto one shared signed comparator
module cmp_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input logic        i_clk,
    input logic        i_rst_n,
    cmp_sched_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    state_t           r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_id;
    logic [WIDTH-1:0] r_cmp_a;
    logic [WIDTH-1:0] r_cmp_b;
    logic [WIDTH-1:0] r_rsp_r;
    logic [N_REQ-1:0] r_rsp_valid;
    logic             w_found;
    logic [IW-1:0]    w_grant;
    logic [IW-1:0]    w_idx;
    // first valid requester at or after the pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = IW'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end
    assign bus.req_ready = (r_state == IDLE && w_found) ? N_REQ'(1) << w_grant : '0;
    assign bus.cmp_a     = r_cmp_a;
    assign bus.cmp_b     = r_cmp_b;
    assign bus.rsp_r     = r_rsp_r;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.busy      = (r_state != IDLE);
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_cmp_a     <= '0;
            r_cmp_b     <= '0;
            r_rsp_r     <= '0;
            r_rsp_valid <= '0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: if (w_found) begin
                    r_id    <= w_grant;
                    r_cmp_a <= bus.req_op_a[int'(w_grant)*WIDTH +: WIDTH];
                    r_cmp_b <= bus.req_op_b[int'(w_grant)*WIDTH +: WIDTH];
                    r_ptr   <= (w_grant == IW'(N_REQ - 1)) ? '0 : w_grant + 1'b1;
                    r_state <= ISSUE;
                end
                ISSUE: r_state <= CAPTURE;
                CAPTURE: begin
                    r_rsp_r     <= bus.cmp_r;
                    r_rsp_valid <= N_REQ'(1) << r_id;
                    r_state     <= RESP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmp_sched.sv
// tb_cmp_sched: directed stimulus, cycle-age reference model and literal response list for cmp_sched
module tb_cmp_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] op_a [4];
    logic [31:0] op_b [4];
    int          checks = 0;
    int          errors = 0;
    bit          done = 1'b0;
    bit          done_chk = 1'b0;
    cmp_sched_if #(.N_REQ(4), .WIDTH(32)) bus ();
    cmp_sched #(.N_REQ(4), .WIDTH(32)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    // external comparator: signed less-than, sentinel operand forces 0
    function automatic logic [31:0] ref_cmp(logic [31:0] a, logic [31:0] b);
        if (a == 32'h7FFF_FFFF || b == 32'h7FFF_FFFF) return 32'd0;
        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endfunction
    function automatic int rr(logic [3:0] v, int p);
        for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction
    assign bus.cmp_r    = ref_cmp(bus.cmp_a, bus.cmp_b);
    assign bus.req_op_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    assign bus.req_op_b = {op_b[3], op_b[2], op_b[1], op_b[0]};
    // model: m_age counts cycles since the last accept (1..3 in flight, >=4 free)
    bit          m_ok = 1'b0;
    int          m_age, m_ptr, m_id, m_g;
    logic [31:0] m_a, m_b, m_rsp;
    always @(posedge clk) begin
        if (!rst_n) begin
            m_ok = 1'b1; m_age = 99; m_ptr = 0; m_id = 0;
            m_a = '0; m_b = '0; m_rsp = '0;
        end else if (m_ok) begin
            if (m_age == 2) m_rsp = ref_cmp(m_a, m_b);
            m_g = rr(bus.req_valid, m_ptr);
            if (m_age >= 4 && m_g >= 0) begin
                m_id = m_g; m_a = op_a[m_g]; m_b = op_b[m_g];
                m_ptr = (m_g + 1) % 4; m_age = 1;
            end else if (m_age < 99) m_age++;
        end
    end
    int          lit_id [13] = '{0, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 0, 3};
    logic [31:0] lit_r  [13] = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1};
    int          n_rsp = 0;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (m_ok) begin
            int g;
            g = rr(bus.req_valid, m_ptr);
            chk("req_ready", 32'(bus.req_ready), (m_age >= 4 && g >= 0) ? 32'(1) << g : 32'd0);
            chk("busy", 32'(bus.busy), (m_age < 4) ? 32'd1 : 32'd0);
            chk("rsp_valid", 32'(bus.rsp_valid), (m_age == 3) ? 32'(1) << m_id : 32'd0);
            chk("rsp_r", bus.rsp_r, m_rsp);
            chk("cmp_a", bus.cmp_a, m_a);
            chk("cmp_b", bus.cmp_b, m_b);
            if (bus.rsp_valid != '0) begin
                if (n_rsp < 13) begin
                    chk("lit_id", 32'(bus.rsp_valid), 32'(1) << lit_id[n_rsp]);
                    chk("lit_r", bus.rsp_r, lit_r[n_rsp]);
                end else chk("extra_rsp", 32'(n_rsp), 32'd12);
                n_rsp++;
            end
        end
        if (done && !done_chk) begin
            done_chk = 1'b1;
            chk("rsp_count", 32'(n_rsp), 32'd13);
        end
    end
    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        rst_n = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < 4; i++) begin op_a[i] = '0; op_b[i] = '0; end
        cyc(2);
        rst_n = 1'b1;
        // single request: -2 < 3
        op_a[0] = 32'hFFFF_FFFE; op_b[0] = 32'd3;
        bus.req_valid = 4'b0001;
        cyc(1);
        bus.req_valid = '0;
        cyc(5);
        // all four continuously after a fresh reset, incl. sentinel pass-through
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        op_a[0] = 32'd1;          op_b[0] = 32'h7FFF_FFFF;
        op_a[1] = 32'd5;          op_b[1] = 32'hFFFF_FFF9;
        op_a[2] = 32'hFFFF_FFF9;  op_b[2] = 32'd5;
        op_a[3] = 32'h8000_0000;  op_b[3] = 32'h7FFF_FFFE;
        bus.req_valid = 4'b1111;
        cyc(17);
        bus.req_valid = '0;
        cyc(4);
        // requester 2 arrives while requester 1 is in flight
        bus.req_valid = 4'b0010;
        cyc(1);
        bus.req_valid = 4'b0100;
        cyc(4);
        bus.req_valid = '0;
        cyc(5);
        // requester 1 pulses and withdraws while busy
        bus.req_valid = 4'b1000;
        cyc(1);
        bus.req_valid = 4'b0010;
        cyc(1);
        bus.req_valid = '0;
        cyc(4);
        bus.req_valid = 4'b0011;
        cyc(5);
        bus.req_valid = '0;
        cyc(5);
        // reset during CAPTURE drops the transaction
        bus.req_valid = 4'b0100;
        cyc(1);
        bus.req_valid = '0;
        cyc(1);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        bus.req_valid = 4'b1001;
        cyc(1);
        bus.req_valid = 4'b1000;
        cyc(4);
        bus.req_valid = '0;
        cyc(6);
        done = 1'b1;
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmp_sched.md
Name: cmp_sched

Overview:
- Round-robin scheduler that shares one external signed less-than comparator (OP_A, OP_B -> R, 32-bit) among N_REQ requesters in the F-extension datapath.
- Serialises requests: accept one, drive the shared comparator, capture R, return it to the winner.
- Lets FP compare/min-max helpers and integer SLT-style users share one compare unit.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/result width.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous active-low reset.
- REQ_VALID  input  N_REQ  per-requester request valid.
- REQ_READY  output  N_REQ  per-requester accept; one-hot or zero.
- REQ_OP_A  input  N_REQ*WIDTH  packed operand A; requester i at bits [i*WIDTH +: WIDTH].
- REQ_OP_B  input  N_REQ*WIDTH  packed operand B, same packing.
- CMP_A  output  WIDTH  registered operand A to the shared comparator.
- CMP_B  output  WIDTH  registered operand B to the shared comparator.
- CMP_R  input  WIDTH  comparator result, combinational from CMP_A/CMP_B.
- RSP_VALID  output  N_REQ  one-hot, one-cycle response strobe.
- RSP_R  output  WIDTH  registered result; valid while any RSP_VALID bit is high.
- BUSY  output  1  high in any state except IDLE.

Behaviour:
Reset (RST low at a clock edge):
- State = IDLE.
- CMP_A, CMP_B, RSP_R = 0. RSP_VALID = 0. REQ_READY = 0.
- Priority pointer = 0, so requester 0 has highest priority.
- Reset mid-transaction drops that transaction. No RSP_VALID is issued for it.

FSM states: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.

IDLE:
- Grant = first i with REQ_VALID[i]=1, searching from pointer upward with wrap-around mod N_REQ.
- REQ_READY[grant] = 1, combinational, this cycle only. Every other REQ_READY bit = 0.
- No valid requests: REQ_READY = 0 and state stays IDLE.
- Handshake completes on an edge where REQ_VALID[i] & REQ_READY[i]. On that edge:
  - latch grant id;
  - CMP_A <= requester's OP_A and CMP_B <= requester's OP_B;
  - pointer <= (grant+1) mod N_REQ;
  - go to ISSUE.

ISSUE:
- CMP_A/CMP_B held stable for one cycle so the comparator settles.
- Go to CAPTURE.

CAPTURE:
- RSP_R <= CMP_R.
- Go to RESP.

RESP:
- RSP_VALID[id] = 1 for exactly this cycle.
- RSP_R is held until the next CAPTURE.
- Go to IDLE.

Timing and handshake rules:
- Latency: response strobe is 3 cycles after the accept edge.
- Throughput: one transaction per 4 cycles at best (accept in IDLE, then ISSUE, CAPTURE, RESP).
- REQ_READY is 0 in ISSUE, CAPTURE and RESP. Requests arriving then wait.
- A requester must hold REQ_VALID and its operands until it sees READY. Deasserting before READY is legal and means no transfer.
- Responses have no backpressure. The requester must sample in the RESP cycle.
- Fairness: each pending requester is served within N_REQ transactions.
- A requester that re-asserts VALID in the RESP cycle competes normally in the next IDLE cycle. Its priority is lowest, because the pointer has moved past it.
- CMP_A/CMP_B keep their last values while IDLE. No toggling without a grant.
- The scheduler passes CMP_R through unmodified. Sentinel handling (0x7FFFFFFF operand forces result 0) belongs to the comparator.

Test Plan:
- Single request: reset, then REQ_VALID[0]=1, OP_A=0xFFFFFFFE (-2), OP_B=0x00000003 -> READY[0] one cycle; CMP_A/B updated next edge; RSP_VALID[0] 3 cycles after accept with RSP_R=1.
- All four valid continuously, pointer=0 after reset -> grants in order 0,1,2,3,0; one accept every 4 cycles; each RSP_VALID one-hot to the matching id.
- Sentinel pass-through: OP_A=0x00000001, OP_B=0x7FFFFFFF -> RSP_R=0. Then OP_A=5, OP_B=-7 -> RSP_R=0. Then OP_A=-7, OP_B=5 -> RSP_R=1.
- Busy arrival: REQ_VALID[2] asserted during ISSUE of requester 1's transaction -> REQ_READY[2] stays 0 until the next IDLE; accepted there; BUSY high throughout both transactions except that IDLE cycle.
- Reset mid-op: RST low during CAPTURE -> no RSP_VALID; next cycle all outputs 0, state IDLE; a subsequent request from requester 3 with requester 0 also valid -> requester 0 granted first.
- Withdrawn request: REQ_VALID[1] pulses for one cycle while BUSY -> no grant, no response; pointer unchanged.
